// File: rtl/wb_burst_copy_master.sv
// Pipelined Wishbone B4 copy master. Each accepted request reads BURST_LEN words from an
// auto-incrementing read window into a local buffer, then writes them to an auto-incrementing
// write window. A slave error aborts the burst and rewinds both windows so a retry repeats it.
//
// Ports:
//   clk_i, reset_i          clock (rising edge), asynchronous active-low reset
//   dreq_i                  transfer request level, sampled only while idle
//   dack_o, done_o, err_o   one-cycle pulses: accepted, completed, aborted
//   adr_o, dat_o, dat_i     word address, write data, read data
//   cyc_o, stb_o, we_o      Wishbone cycle, strobe, write enable
//   ack_i, err_i, stall_i   Wishbone acknowledge, error, pipelined stall
module wb_burst_copy_master #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned BURST_LEN = 4,
    parameter logic [ADDR_WIDTH-1:0] RD_BASE = 16'h0000,
    parameter logic [ADDR_WIDTH-1:0] WR_BASE = 16'h8000
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  dreq_i,
    output logic                  dack_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [ADDR_WIDTH-1:0] adr_o,
    output logic [DATA_WIDTH-1:0] dat_o,
    input  logic [DATA_WIDTH-1:0] dat_i,
    output logic                  cyc_o,
    output logic                  stb_o,
    output logic                  we_o,
    input  logic                  ack_i,
    input  logic                  err_i,
    input  logic                  stall_i
);

    localparam int unsigned CW = $clog2(BURST_LEN + 1);
    localparam int unsigned IW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CW-1:0] LenC = CW'(BURST_LEN);
    localparam logic [ADDR_WIDTH-1:0] LenA = ADDR_WIDTH'(BURST_LEN);

    typedef enum logic [1:0] {StIdle, StRead, StWrite} state_e;

    state_e                  state_q;
    logic [ADDR_WIDTH-1:0]   rd_ptr_q, wr_ptr_q;
    logic [ADDR_WIDTH-1:0]   rd_start_q, wr_start_q;
    logic [CW-1:0]           issued_q, ack_cnt_q;
    logic [DATA_WIDTH-1:0]   mem_q [BURST_LEN];

    logic          accept, ack_ok, last_issue, last_ack;
    logic [CW-1:0] issued_inc, ack_inc;

    always_comb begin
        accept     = stb_o & ~stall_i;
        // Acks past the burst length are dropped
        ack_ok     = ack_i & (ack_cnt_q != LenC);
        issued_inc = issued_q + CW'(1);
        ack_inc    = ack_cnt_q + CW'(1);
        last_issue = (issued_inc == LenC);
        last_ack   = (ack_inc == LenC);
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q    <= StIdle;
            rd_ptr_q   <= RD_BASE;
            wr_ptr_q   <= WR_BASE;
            rd_start_q <= RD_BASE;
            wr_start_q <= WR_BASE;
            issued_q   <= '0;
            ack_cnt_q  <= '0;
            for (int i = 0; i < int'(BURST_LEN); i++) begin
                mem_q[i] <= '0;
            end
            dack_o     <= 1'b0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
            adr_o      <= '0;
            dat_o      <= '0;
            cyc_o      <= 1'b0;
            stb_o      <= 1'b0;
            we_o       <= 1'b0;
        end else begin
            dack_o <= 1'b0;
            done_o <= 1'b0;
            err_o  <= 1'b0;
            if (state_q != StIdle && err_i) begin
                // Abort wins over any same-cycle ack; rewind so a retry repeats the window
                cyc_o    <= 1'b0;
                stb_o    <= 1'b0;
                we_o     <= 1'b0;
                err_o    <= 1'b1;
                rd_ptr_q <= rd_start_q;
                wr_ptr_q <= wr_start_q;
                state_q  <= StIdle;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (dreq_i) begin
                            dack_o     <= 1'b1;
                            cyc_o      <= 1'b1;
                            stb_o      <= 1'b1;
                            we_o       <= 1'b0;
                            adr_o      <= rd_ptr_q;
                            rd_start_q <= rd_ptr_q;
                            wr_start_q <= wr_ptr_q;
                            issued_q   <= '0;
                            ack_cnt_q  <= '0;
                            state_q    <= StRead;
                        end
                    end
                    StRead: begin
                        if (accept) begin
                            issued_q <= issued_inc;
                            adr_o    <= adr_o + ADDR_WIDTH'(1);
                            if (last_issue) stb_o <= 1'b0;
                        end
                        if (ack_ok) begin
                            mem_q[ack_cnt_q[IW-1:0]] <= dat_i;
                            ack_cnt_q                <= ack_inc;
                            if (last_ack) begin
                                state_q   <= StWrite;
                                we_o      <= 1'b1;
                                stb_o     <= 1'b1;
                                adr_o     <= wr_ptr_q;
                                // With a one-word burst the buffer is filled on this very edge
                                dat_o     <= (ack_cnt_q == '0) ? dat_i : mem_q[0];
                                issued_q  <= '0;
                                ack_cnt_q <= '0;
                                rd_ptr_q  <= rd_ptr_q + LenA;
                            end
                        end
                    end
                    StWrite: begin
                        if (accept) begin
                            issued_q <= issued_inc;
                            adr_o    <= adr_o + ADDR_WIDTH'(1);
                            if (last_issue) stb_o <= 1'b0;
                            else dat_o <= mem_q[issued_inc[IW-1:0]];
                        end
                        if (ack_ok) begin
                            ack_cnt_q <= ack_inc;
                            if (last_ack) begin
                                cyc_o    <= 1'b0;
                                stb_o    <= 1'b0;
                                we_o     <= 1'b0;
                                done_o   <= 1'b1;
                                wr_ptr_q <= wr_ptr_q + LenA;
                                state_q  <= StIdle;
                            end
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_wb_burst_copy_master.sv
module tb_wb_burst_copy_master;

    logic        clk, reset_i, dreq_i, ack_i, err_i, stall_i;
    logic [15:0] dat_i;
    logic        dack_o, done_o, err_o, cyc_o, stb_o, we_o;
    logic [15:0] adr_o, dat_o;

    logic        dreq2, ack2;
    logic [15:0] dat2_i;
    logic        dack2, done2, err2, cyc2, stb2, we2;
    logic [15:0] adr2, dat2_o;

    wb_burst_copy_master dut (
        .clk_i(clk), .reset_i(reset_i), .dreq_i(dreq_i), .dack_o(dack_o), .done_o(done_o),
        .err_o(err_o), .adr_o(adr_o), .dat_o(dat_o), .dat_i(dat_i), .cyc_o(cyc_o),
        .stb_o(stb_o), .we_o(we_o), .ack_i(ack_i), .err_i(err_i), .stall_i(stall_i)
    );

    wb_burst_copy_master #(.RD_BASE(16'hFFFE)) dut_wrap (
        .clk_i(clk), .reset_i(reset_i), .dreq_i(dreq2), .dack_o(dack2), .done_o(done2),
        .err_o(err2), .adr_o(adr2), .dat_o(dat2_o), .dat_i(dat2_i), .cyc_o(cyc2),
        .stb_o(stb2), .we_o(we2), .ack_i(ack2), .err_i(1'b0), .stall_i(1'b0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int          lat;
        int          stall;
        int          err_at;
        logic [15:0] rd_base;
        logic [15:0] wr_base;
        int          nwr;
        int          done;
        int          err;
        int          max_out;
    } row_t;

    typedef struct {
        int          due;
        logic [15:0] adr;
        logic        we;
    } req_t;

    row_t        rows [6];
    req_t        pq [$];
    logic [15:0] rd_log [$], wr_adr_log [$], wr_dat_log [$], rd2_log [$];

    int checks = 0, errors = 0;
    int cyc_n = 0, lat = 1, stall_left = 0, err_at = 0, wr_acks = 0, rd_acks = 0;
    int rd_acks_at_w = -1, max_out = 0, gaps = 0, in_burst = 0, dack_cycle = -1;
    int done_seen = 0, err_seen = 0, stall_seen = 0, stall_bad = 0, done2_seen = 0;
    logic [15:0] stall_exp_adr = '0;
    logic        acc2 = 1'b0;

    function automatic logic [15:0] rd_data(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'hC3A5;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One clock: observe outputs after the edge, then drive slave responses for this cycle
    task automatic tick();
        req_t r;
        @(posedge clk);
        #1;
        cyc_n++;
        if (dack_o) begin
            dack_cycle = cyc_n;
            in_burst   = 1;
        end
        if (done_o) done_seen++;
        if (err_o) err_seen++;
        if (done_o || err_o) in_burst = 0;
        else if (in_burst != 0 && !cyc_o) gaps++;

        ack_i = 1'b0;
        err_i = 1'b0;
        dat_i = '0;
        if (!cyc_o) pq.delete();
        if (pq.size() > 0 && pq[0].due == cyc_n) begin
            r = pq.pop_front();
            if (r.we) begin
                wr_acks++;
                if (wr_acks == err_at) err_i = 1'b1;
                else ack_i = 1'b1;
            end else begin
                rd_acks++;
                ack_i = 1'b1;
                dat_i = rd_data(r.adr);
            end
        end

        stall_i = 1'b0;
        if (stall_left > 0 && cyc_o && stb_o && !we_o && rd_log.size() == 1) begin
            stall_i = 1'b1;
            stall_left--;
            stall_seen++;
            if (adr_o != stall_exp_adr) stall_bad++;
        end
        if (cyc_o && stb_o && !stall_i) begin
            pq.push_back('{cyc_n + lat, adr_o, we_o});
            if (we_o) begin
                if (wr_adr_log.size() == 0) rd_acks_at_w = rd_acks;
                wr_adr_log.push_back(adr_o);
                wr_dat_log.push_back(dat_o);
            end else begin
                rd_log.push_back(adr_o);
            end
        end
        if (pq.size() > max_out) max_out = pq.size();

        // Zero-wait slave for the wrap-around instance
        ack2 = acc2;
        acc2 = cyc2 && stb2;
        if (cyc2 && stb2 && !we2) rd2_log.push_back(adr2);
        if (done2) done2_seen++;
    endtask

    task automatic clear_logs();
        rd_log.delete();
        wr_adr_log.delete();
        wr_dat_log.delete();
        wr_acks = 0;
        rd_acks = 0;
        rd_acks_at_w = -1;
        max_out = 0;
        gaps = 0;
        done_seen = 0;
        err_seen = 0;
        stall_seen = 0;
        stall_bad = 0;
        dack_cycle = -1;
    endtask

    task automatic run_row(input int k);
        int n;
        int req_c;
        row_t rw;
        rw = rows[k];
        clear_logs();
        lat = rw.lat;
        stall_left = rw.stall;
        stall_exp_adr = rw.rd_base + 16'd1;
        err_at = rw.err_at;
        dreq_i = 1'b1;
        req_c = cyc_n;
        tick();
        dreq_i = 1'b0;
        n = 0;
        while (done_seen == 0 && err_seen == 0 && n < 80) begin
            tick();
            n++;
        end
        tick();
        tick();
        check($sformatf("row%0d_timeout", k), 64'(n >= 80), 64'd0);
        check($sformatf("row%0d_dack_latency", k), 64'(dack_cycle - req_c), 64'd1);
        check($sformatf("row%0d_nrd", k), 64'(rd_log.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < rd_log.size())
                check($sformatf("row%0d_rd_adr%0d", k, i), 64'(rd_log[i]),
                      64'(rw.rd_base + 16'(i)));
        end
        check($sformatf("row%0d_nwr", k), 64'(wr_adr_log.size()), 64'(rw.nwr));
        for (int i = 0; i < 4; i++) begin
            if (i < wr_adr_log.size()) begin
                check($sformatf("row%0d_wr_adr%0d", k, i), 64'(wr_adr_log[i]),
                      64'(rw.wr_base + 16'(i)));
                check($sformatf("row%0d_wr_dat%0d", k, i), 64'(wr_dat_log[i]),
                      64'(rd_data(rw.rd_base + 16'(i))));
            end
        end
        check($sformatf("row%0d_done", k), 64'(done_seen), 64'(rw.done));
        check($sformatf("row%0d_err", k), 64'(err_seen), 64'(rw.err));
        check($sformatf("row%0d_cyc_gaps", k), 64'(gaps), 64'd0);
        check($sformatf("row%0d_max_outstanding", k), 64'(max_out), 64'(rw.max_out));
        check($sformatf("row%0d_rd_acks_before_write", k), 64'(rd_acks_at_w), 64'd4);
        check($sformatf("row%0d_stall_cycles", k), 64'(stall_seen), 64'(rw.stall));
        check($sformatf("row%0d_stall_adr_hold", k), 64'(stall_bad), 64'd0);
    endtask

    initial begin
        //         lat stall err_at rd_base   wr_base   nwr done err max_out
        rows[0] = '{1, 0, 0, 16'h0000, 16'h8000, 4, 1, 0, 1};
        rows[1] = '{1, 0, 3, 16'h0004, 16'h8004, 4, 0, 1, 1};  // error on 3rd write ack
        rows[2] = '{1, 0, 0, 16'h0004, 16'h8004, 4, 1, 0, 1};  // retry repeats the window
        rows[3] = '{1, 3, 0, 16'h0008, 16'h8008, 4, 1, 0, 1};  // 3-cycle stall on beat 1
        rows[4] = '{2, 0, 0, 16'h000C, 16'h800C, 4, 1, 0, 2};  // 2-cycle ack latency
        rows[5] = '{1, 0, 0, 16'h0000, 16'h8000, 4, 1, 0, 1};  // after mid-burst reset

        reset_i = 1'b0;
        dreq_i = 1'b0;
        ack_i = 1'b0;
        err_i = 1'b0;
        stall_i = 1'b0;
        dat_i = '0;
        dreq2 = 1'b0;
        ack2 = 1'b0;
        dat2_i = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 64'({dack_o, done_o, err_o, cyc_o, stb_o, we_o, adr_o, dat_o}),
              64'd0);
        check("reset_outputs_wrap", 64'({dack2, done2, err2, cyc2, stb2, we2, adr2, dat2_o}),
              64'd0);
        reset_i = 1'b1;
        tick();

        for (int k = 0; k < 5; k++) run_row(k);

        // Reset in the middle of a read burst
        clear_logs();
        lat = 1;
        stall_left = 0;
        err_at = 0;
        dreq_i = 1'b1;
        tick();
        dreq_i = 1'b0;
        tick();
        tick();
        check("mid_read_cyc", 64'({cyc_o, we_o}), 64'b10);
        #2;
        reset_i = 1'b0;
        #1;
        check("async_reset_outputs",
              64'({dack_o, done_o, err_o, cyc_o, stb_o, we_o, adr_o, dat_o}), 64'd0);
        tick();
        tick();
        reset_i = 1'b1;
        repeat (3) tick();
        check("reset_no_done", 64'(done_seen), 64'd0);
        check("reset_no_err", 64'(err_seen), 64'd0);

        // Stray ack/err while idle must be ignored
        ack_i = 1'b1;
        err_i = 1'b1;
        @(posedge clk);
        #1;
        check("idle_err_ignored", 64'({err_o, cyc_o}), 64'd0);
        ack_i = 1'b0;
        err_i = 1'b0;
        tick();

        run_row(5);

        // Read window wrapping past the top of the address space
        rd2_log.delete();
        done2_seen = 0;
        dreq2 = 1'b1;
        tick();
        dreq2 = 1'b0;
        for (int n = 0; n < 60 && done2_seen == 0; n++) tick();
        check("wrap_done", 64'(done2_seen), 64'd1);
        check("wrap_nrd", 64'(rd2_log.size()), 64'd4);
        begin
            logic [15:0] exp_wrap [4];
            exp_wrap = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
            for (int i = 0; i < 4; i++) begin
                if (i < rd2_log.size())
                    check($sformatf("wrap_rd_adr%0d", i), 64'(rd2_log[i]), 64'(exp_wrap[i]));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
